// File: rtl/ucode_pkg.sv
// Shared definitions for the microcode sequencer: layer kinds, pipeline word
// bit positions and the layer-slot one-hot Mode helper.
package ucode_pkg;

  typedef enum logic [1:0] {
    KIND_CONV = 2'd0,
    KIND_POOL = 2'd1,
    KIND_FC   = 2'd2,
    KIND_OFF  = 2'd3
  } kind_e;

  localparam int unsigned PIPE_W          = 16;
  localparam int unsigned PIPE_CMP_LSB    = 14;  // [15:14] comparator ctrl
  localparam int unsigned PIPE_WR_MUX     = 13;
  localparam int unsigned PIPE_ADD_IN     = 12;
  localparam int unsigned PIPE_ADD_LSB    = 10;  // [11:10] adder ctrl
  localparam int unsigned PIPE_MUL_EN_LSB = 4;   // [9:4] mul path enables
  localparam int unsigned PIPE_MUL_CTRL   = 3;
  localparam int unsigned PIPE_MUL_SEL    = 2;
  localparam int unsigned PIPE_ALU_MUX    = 1;
  localparam int unsigned PIPE_DONE       = 0;

  localparam int unsigned MODE_MAX = 32;

  // Slot 0 maps to the MSB of a num_layers-wide one-hot; caller truncates.
  function automatic logic [MODE_MAX-1:0] mode_onehot(input int unsigned slot,
                                                      input int unsigned num_layers);
    mode_onehot = MODE_MAX'(1) << (num_layers - 1 - slot);
  endfunction

endpackage

// File: rtl/ucode_loop_ctr.sv
// Nested loop counters: h innermost (only when enabled), then w, then d.
module ucode_loop_ctr #(
  parameter int unsigned W_BITS = 9,
  parameter int unsigned D_BITS = 5,
  parameter int unsigned H_BITS = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              adv,
  input  logic              h_en,
  input  logic [W_BITS-1:0] w_max,
  input  logic [D_BITS-1:0] d_max,
  input  logic [H_BITS-1:0] h_max,
  output logic [H_BITS-1:0] h,
  output logic [W_BITS-1:0] w,
  output logic [D_BITS-1:0] d,
  output logic              last_c
);

  logic h_last, w_last, d_last;

  // With h disabled it stays at 0 and counts as already at its bound.
  always_comb begin
    h_last = !h_en || (h == h_max);
    w_last = (w == w_max);
    d_last = (d == d_max);
    last_c = h_last && w_last && d_last;
  end

  // Advance the innermost counter, carrying outward with exact wrap at max.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h <= '0;
      w <= '0;
      d <= '0;
    end else if (clr) begin
      h <= '0;
      w <= '0;
      d <= '0;
    end else if (adv) begin
      if (!h_last) begin
        h <= h + H_BITS'(1);
      end else begin
        h <= '0;
        if (!w_last) begin
          w <= w + W_BITS'(1);
        end else begin
          w <= '0;
          d <= d_last ? '0 : d + D_BITS'(1);
        end
      end
    end
  end

endmodule

// File: rtl/ucode_sequencer.sv
// Walks the enabled layer slots and emits one microcode bundle per loop tuple
// through a registered valid/ready output stage.
module ucode_sequencer
  import ucode_pkg::*;
#(
  parameter int unsigned NUM_LAYERS = 7,
  parameter int unsigned W_BITS     = 9,
  parameter int unsigned D_BITS     = 5,
  parameter int unsigned H_BITS     = 4,
  parameter int unsigned LANES      = 5
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  cfg_we,
  input  logic [$clog2(NUM_LAYERS)-1:0]         cfg_slot,
  input  logic [1:0]                            cfg_kind,
  input  logic [W_BITS-1:0]                     cfg_w_max,
  input  logic [D_BITS-1:0]                     cfg_d_max,
  input  logic [H_BITS-1:0]                     cfg_h_max,
  input  logic                                  start,
  output logic                                  busy,
  output logic                                  done,
  output logic                                  ucode_valid,
  input  logic                                  ucode_ready,
  output logic [15:0]                           pipeline_ucode,
  output logic [W_BITS+D_BITS+NUM_LAYERS:0]     data_read_ucode,
  output logic [W_BITS+D_BITS+NUM_LAYERS:0]     data_write_ucode,
  output logic [4+D_BITS+NUM_LAYERS:0]          weight_read_ucode
);

  localparam int unsigned SLOT_BITS = $clog2(NUM_LAYERS);
  localparam int unsigned PTR_BITS  = SLOT_BITS + 1;
  localparam int unsigned DW        = W_BITS + D_BITS + NUM_LAYERS + 1;
  localparam int unsigned WW        = 4 + D_BITS + NUM_LAYERS + 1;
  localparam logic [W_BITS-1:0] LANES_W = W_BITS'(LANES);

  typedef enum logic [1:0] {S_IDLE, S_SEEK, S_EMIT, S_DONE} state_e;

  state_e state_q, state_d;

  kind_e             kind_q [NUM_LAYERS];
  logic [W_BITS-1:0] wmax_q [NUM_LAYERS];
  logic [D_BITS-1:0] dmax_q [NUM_LAYERS];
  logic [H_BITS-1:0] hmax_q [NUM_LAYERS];

  logic [SLOT_BITS-1:0] cur_slot, found_idx;
  logic [PTR_BITS-1:0]  seek_ptr;
  logic                 found;

  logic load_word, ctr_clr, ctr_adv, take_slot, run_start, fire;

  kind_e             cur_kind;
  logic [W_BITS-1:0] cur_wmax;
  logic [D_BITS-1:0] cur_dmax;
  logic [H_BITS-1:0] cur_hmax;
  logic [NUM_LAYERS-1:0] mode;

  logic [H_BITS-1:0] h;
  logic [W_BITS-1:0] w;
  logic [D_BITS-1:0] d;
  logic              ctr_last_c;

  logic [15:0]       pipe_c;
  logic [DW-1:0]     rd_c, wr_c;
  logic [WW-1:0]     wt_c;

  // Descriptor table; writes are dropped while a run is in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_LAYERS; i++) begin
        kind_q[i] <= KIND_OFF;
        wmax_q[i] <= '0;
        dmax_q[i] <= '0;
        hmax_q[i] <= '0;
      end
    end else if (cfg_we && !busy && (32'(cfg_slot) < NUM_LAYERS)) begin
      kind_q[cfg_slot] <= kind_e'(cfg_kind);
      wmax_q[cfg_slot] <= cfg_w_max;
      dmax_q[cfg_slot] <= cfg_d_max;
      hmax_q[cfg_slot] <= cfg_h_max;
    end
  end

  // First enabled slot at or after seek_ptr; while emitting this also tells
  // whether any enabled slot follows the current one.
  always_comb begin
    found     = 1'b0;
    found_idx = '0;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      if (!found && (PTR_BITS'(i) >= seek_ptr) && (kind_q[i] != KIND_OFF)) begin
        found     = 1'b1;
        found_idx = SLOT_BITS'(i);
      end
    end
  end

  // Current slot descriptor and its Mode one-hot.
  always_comb begin
    cur_kind = kind_q[cur_slot];
    cur_wmax = wmax_q[cur_slot];
    cur_dmax = dmax_q[cur_slot];
    cur_hmax = hmax_q[cur_slot];
    mode     = NUM_LAYERS'(mode_onehot(32'(cur_slot), NUM_LAYERS));
  end

  ucode_loop_ctr #(
    .W_BITS(W_BITS),
    .D_BITS(D_BITS),
    .H_BITS(H_BITS)
  ) u_loop_ctr (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (ctr_clr),
    .adv    (ctr_adv),
    .h_en   (cur_kind == KIND_CONV),
    .w_max  (cur_wmax),
    .d_max  (cur_dmax),
    .h_max  (cur_hmax),
    .h      (h),
    .w      (w),
    .d      (d),
    .last_c (ctr_last_c)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next state and control strobes. Each tuple is loaded into the output
  // stage one cycle after it becomes current; a fire retires it.
  always_comb begin
    state_d   = state_q;
    load_word = 1'b0;
    ctr_clr   = 1'b0;
    ctr_adv   = 1'b0;
    take_slot = 1'b0;
    run_start = 1'b0;
    fire      = ucode_valid && ucode_ready;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_SEEK;
          run_start = 1'b1;
        end
      end
      S_SEEK: begin
        if (found) begin
          state_d   = S_EMIT;
          take_slot = 1'b1;
          ctr_clr   = 1'b1;
        end else begin
          state_d = S_DONE;
        end
      end
      S_EMIT: begin
        if (!ucode_valid) begin
          load_word = 1'b1;
        end else if (ucode_ready) begin
          if (ctr_last_c) state_d = S_SEEK;
          else            ctr_adv = 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Slot pointer bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_slot <= '0;
      seek_ptr <= '0;
    end else if (run_start) begin
      seek_ptr <= '0;
    end else if (take_slot) begin
      cur_slot <= found_idx;
      seek_ptr <= PTR_BITS'(found_idx) + PTR_BITS'(1);
    end
  end

  // Microcode bundle for the current tuple.
  always_comb begin
    pipe_c = '0;
    rd_c   = '0;
    wr_c   = '0;
    wt_c   = '0;
    pipe_c[PIPE_CMP_LSB +: 2] = 2'b01;
    pipe_c[PIPE_WR_MUX]       = 1'b0;
    case (cur_kind)
      KIND_CONV: begin
        pipe_c[PIPE_ADD_IN]          = (h != '0);
        pipe_c[PIPE_ADD_LSB +: 2]    = (h == cur_hmax) ? 2'b11 : 2'b00;
        pipe_c[PIPE_MUL_EN_LSB +: 6] = (h == '0) ? 6'b111100 : 6'b011100;
        wt_c = {4'(h), d, mode, 1'b1};
        rd_c = {w, D_BITS'(h), mode, 1'b1};
        wr_c = {w, d, mode, (h == cur_hmax)};
      end
      KIND_POOL: begin
        pipe_c[PIPE_MUL_CTRL] = 1'b1;
        pipe_c[PIPE_MUL_SEL]  = 1'b1;
        pipe_c[PIPE_ALU_MUX]  = 1'b1;
        rd_c = {{w[W_BITS-2:0], 1'b0}, d, mode, 1'b1};
        wr_c = {w, d, mode, 1'b1};
      end
      KIND_FC: begin
        pipe_c[PIPE_ADD_IN]          = (w != '0);
        pipe_c[PIPE_ADD_LSB +: 2]    = (w == cur_wmax) ? 2'b11 : 2'b00;
        pipe_c[PIPE_MUL_EN_LSB +: 6] = (w == '0) ? 6'b111111 : 6'b011111;
        pipe_c[PIPE_DONE]            = ctr_last_c && !found;
        wt_c = {4'(w), d, mode, 1'b1};
        rd_c = {w * LANES_W, D_BITS'(0), mode, 1'b1};
        wr_c = {W_BITS'(d), D_BITS'(0), mode, (w == cur_wmax)};
      end
      default: ;
    endcase
  end

  // Registered outputs: status flags and the valid/ready output stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy              <= 1'b0;
      done              <= 1'b0;
      ucode_valid       <= 1'b0;
      pipeline_ucode    <= '0;
      data_read_ucode   <= '0;
      data_write_ucode  <= '0;
      weight_read_ucode <= '0;
    end else begin
      busy <= (state_d == S_SEEK) || (state_d == S_EMIT);
      done <= (state_d == S_DONE);
      if (load_word) begin
        ucode_valid       <= 1'b1;
        pipeline_ucode    <= pipe_c;
        data_read_ucode   <= rd_c;
        data_write_ucode  <= wr_c;
        weight_read_ucode <= wt_c;
      end else if (fire) begin
        ucode_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ucode_sequencer.sv
// Bench for ucode_sequencer: table of slot configurations, a reference model
// feeding a scoreboard queue, and hand-written multi-cycle sequences.
module tb_ucode_sequencer;

  localparam int unsigned NL = 7;
  localparam int unsigned WB = 9;
  localparam int unsigned DB = 5;
  localparam int unsigned HB = 4;
  localparam int unsigned LN = 5;
  localparam int unsigned DW = WB + DB + NL + 1;
  localparam int unsigned WW = 4 + DB + NL + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cfg_we = 1'b0;
  logic [2:0]    cfg_slot = '0;
  logic [1:0]    cfg_kind = '0;
  logic [WB-1:0] cfg_w_max = '0;
  logic [DB-1:0] cfg_d_max = '0;
  logic [HB-1:0] cfg_h_max = '0;
  logic          start = 1'b0;
  logic          busy, done, ucode_valid;
  logic          ucode_ready = 1'b1;
  logic [15:0]   pipeline_ucode;
  logic [DW-1:0] data_read_ucode, data_write_ucode;
  logic [WW-1:0] weight_read_ucode;

  ucode_sequencer #(
    .NUM_LAYERS(NL), .W_BITS(WB), .D_BITS(DB), .H_BITS(HB), .LANES(LN)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .cfg_we            (cfg_we),
    .cfg_slot          (cfg_slot),
    .cfg_kind          (cfg_kind),
    .cfg_w_max         (cfg_w_max),
    .cfg_d_max         (cfg_d_max),
    .cfg_h_max         (cfg_h_max),
    .start             (start),
    .busy              (busy),
    .done              (done),
    .ucode_valid       (ucode_valid),
    .ucode_ready       (ucode_ready),
    .pipeline_ucode    (pipeline_ucode),
    .data_read_ucode   (data_read_ucode),
    .data_write_ucode  (data_write_ucode),
    .weight_read_ucode (weight_read_ucode)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0]   pipe;
    logic [DW-1:0] rd;
    logic [DW-1:0] wr;
    logic [WW-1:0] wt;
  } word_t;

  typedef struct {
    int         slot_a;
    logic [1:0] kind_a;
    int         wa, da, ha;
    int         slot_b;
    logic [1:0] kind_b;
    int         wb, db, hb;
    int         rmode;      // 0 ready high, 1 toggle, 2 random
    int         exp_words;
  } case_t;

  word_t exp_q[$];
  int    rec_rdw[$];
  int    rec_p0[$];
  int    rec_wren[$];
  int    rec_add[$];
  int    rec_wt[$];

  int n_checks = 0;
  int n_fail   = 0;
  int n_words  = 0;
  int rmode    = 0;

  int m_kind[NL];
  int m_w[NL];
  int m_d[NL];
  int m_h[NL];

  logic [127:0] prev_snap;
  bit           stall_prev = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model of one bundle.
  function automatic word_t model_word(int slot, int k, int h, int w, int d,
                                       int wm, int hm, bit fin);
    word_t         r;
    logic [NL-1:0] mode;
    mode = NL'(1) << (NL - 1 - slot);
    r = '0;
    case (k)
      0: begin
        r.pipe = {2'b01, 1'b0, (h != 0), (h == hm) ? 2'b11 : 2'b00,
                  (h == 0) ? 6'b111100 : 6'b011100, 4'b0000};
        r.wt = {4'(h), DB'(d), mode, 1'b1};
        r.rd = {WB'(w), DB'(h), mode, 1'b1};
        r.wr = {WB'(w), DB'(d), mode, (h == hm)};
      end
      1: begin
        r.pipe = 16'b01_0_0_00_000000_1110;
        r.wt = '0;
        r.rd = {WB'(w * 2), DB'(d), mode, 1'b1};
        r.wr = {WB'(w), DB'(d), mode, 1'b1};
      end
      2: begin
        r.pipe = {2'b01, 1'b0, (w != 0), (w == wm) ? 2'b11 : 2'b00,
                  (w == 0) ? 6'b111111 : 6'b011111, 3'b000, fin};
        r.wt = {4'(w), DB'(d), mode, 1'b1};
        r.rd = {WB'(w * LN), DB'(0), mode, 1'b1};
        r.wr = {WB'(d), DB'(0), mode, (w == wm)};
      end
      default: r = '0;
    endcase
    return r;
  endfunction

  // Push the whole expected word stream of a run from the bench's own table copy.
  task automatic gen_expected();
    int last_en;
    last_en = -1;
    for (int s = 0; s < NL; s++) if (m_kind[s] != 3) last_en = s;
    for (int s = 0; s < NL; s++) begin
      if (m_kind[s] != 3) begin
        for (int d = 0; d <= m_d[s]; d++)
          for (int w = 0; w <= m_w[s]; w++)
            for (int h = 0; h <= ((m_kind[s] == 0) ? m_h[s] : 0); h++)
              exp_q.push_back(model_word(s, m_kind[s], h, w, d, m_w[s], m_h[s],
                (m_kind[s] == 2) && (s == last_en) && (d == m_d[s]) && (w == m_w[s])));
      end
    end
  endtask

  task automatic cfg_write(input int slot, input int kind, input int w, input int d, input int h);
    cfg_we    = 1'b1;
    cfg_slot  = 3'(slot);
    cfg_kind  = 2'(kind);
    cfg_w_max = WB'(w);
    cfg_d_max = DB'(d);
    cfg_h_max = HB'(h);
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic set_slot(input int slot, input int kind, input int w, input int d, input int h);
    cfg_write(slot, kind, w, d, h);
    m_kind[slot] = kind;
    m_w[slot] = w;
    m_d[slot] = d;
    m_h[slot] = h;
  endtask

  task automatic clear_rec();
    rec_rdw.delete();
    rec_p0.delete();
    rec_wren.delete();
    rec_add.delete();
    rec_wt.delete();
    n_words = 0;
  endtask

  // Pulse start, then wait (bounded) for done.
  task automatic run_and_wait(input string name);
    bit got;
    start = 1'b1;
    tick();
    start = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 3000 && !got; c++) begin
      if (done) got = 1'b1;
      else tick();
    end
    check({name, "_done_seen"}, 128'(got), 128'(1));
    tick();
  endtask

  // Ready pattern driven just after each rising edge.
  always @(posedge clk) begin
    #1;
    case (rmode)
      1:       ucode_ready = ~ucode_ready;
      2:       ucode_ready = 1'($urandom_range(0, 1));
      default: ucode_ready = 1'b1;
    endcase
  end

  // Monitor: scoreboard pop on fire, hold check while stalled.
  always @(negedge clk) begin
    logic [127:0] snap;
    word_t        got, e;
    got  = {pipeline_ucode, data_read_ucode, data_write_ucode, weight_read_ucode};
    snap = 128'({ucode_valid, got});
    if (rst_n) begin
      if (stall_prev) check("stall_hold", snap, prev_snap);
      if (ucode_valid && ucode_ready) begin
        n_words++;
        rec_rdw.push_back(int'(data_read_ucode[DW-1 -: WB]));
        rec_p0.push_back(int'(pipeline_ucode[0]));
        rec_wren.push_back(int'(data_write_ucode[0]));
        rec_add.push_back(int'(pipeline_ucode[11:10]));
        rec_wt.push_back(int'(weight_read_ucode));
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL extra_word: got %0h required none at %0t", got, $time);
        end else begin
          e = exp_q.pop_front();
          check("word", 128'(got), 128'(e));
        end
      end
      stall_prev = ucode_valid && !ucode_ready;
      prev_snap  = snap;
    end else begin
      stall_prev = 1'b0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    case_t cases[7];
    int    seen_done;
    cases[0] = '{0, 2'd0, 1, 0, 1, 0, 2'd3, 0, 0, 0, 0, 4};
    cases[1] = '{0, 2'd0, 1, 0, 1, 0, 2'd3, 0, 0, 0, 1, 4};
    cases[2] = '{2, 2'd1, 3, 1, 0, 0, 2'd3, 0, 0, 0, 0, 8};
    cases[3] = '{6, 2'd2, 3, 0, 0, 0, 2'd3, 0, 0, 0, 0, 4};
    cases[4] = '{1, 2'd0, 0, 0, 0, 4, 2'd2, 2, 1, 0, 2, 7};
    cases[5] = '{3, 2'd2, 1, 0, 0, 5, 2'd1, 0, 0, 0, 1, 3};
    cases[6] = '{0, 2'd0, 2, 1, 3, 0, 2'd3, 0, 0, 0, 2, 24};
    for (int s = 0; s < NL; s++) m_kind[s] = 3;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_done", 128'(done), 128'(0));
    check("rst_valid", 128'(ucode_valid), 128'(0));
    check("rst_words", 128'({pipeline_ucode, data_read_ucode, data_write_ucode, weight_read_ucode}), 128'(0));
    rst_n = 1'b1;
    tick();

    // All slots disabled straight out of reset: done two cycles after start.
    start = 1'b1;
    tick();
    start = 1'b0;
    check("off_busy_c1", 128'(busy), 128'(1));
    check("off_done_c1", 128'(done), 128'(0));
    tick();
    check("off_done_c2", 128'(done), 128'(1));
    check("off_valid_c2", 128'(ucode_valid), 128'(0));
    check("off_busy_c2", 128'(busy), 128'(0));
    tick();
    check("off_done_c3", 128'(done), 128'(0));

    // Table-driven runs.
    for (int c = 0; c < 7; c++) begin
      rmode = 0;
      for (int s = 0; s < NL; s++) set_slot(s, 3, 0, 0, 0);
      set_slot(cases[c].slot_a, cases[c].kind_a, cases[c].wa, cases[c].da, cases[c].ha);
      if (cases[c].kind_b != 2'd3)
        set_slot(cases[c].slot_b, cases[c].kind_b, cases[c].wb, cases[c].db, cases[c].hb);
      rmode = cases[c].rmode;
      clear_rec();
      gen_expected();
      run_and_wait($sformatf("case%0d", c));
      check($sformatf("case%0d_words", c), 128'(n_words), 128'(cases[c].exp_words));
      check($sformatf("case%0d_queue_left", c), 128'(exp_q.size()), 128'(0));
      check($sformatf("case%0d_idle", c), 128'({busy, ucode_valid}), 128'(0));
      exp_q.delete();
      if ((c == 0 || c == 1) && n_words == 4) begin
        check($sformatf("case%0d_wr_en", c), 128'({rec_wren[0][0], rec_wren[1][0], rec_wren[2][0], rec_wren[3][0]}), 128'(4'b0101));
        check($sformatf("case%0d_adder", c), 128'({rec_add[0][1:0], rec_add[1][1:0], rec_add[2][1:0], rec_add[3][1:0]}), 128'(8'b00_11_00_11));
      end
      if (c == 2 && n_words == 8) begin
        for (int i = 0; i < 8; i++) begin
          check("pool_rd_width", 128'(rec_rdw[i]), 128'((i % 4) * 2));
          check("pool_weight", 128'(rec_wt[i]), 128'(0));
        end
      end
      if (c == 3 && n_words == 4) begin
        for (int i = 0; i < 4; i++) begin
          check("fc_rd_width", 128'(rec_rdw[i]), 128'(i * 5));
          check("fc_last", 128'(rec_p0[i]), 128'((i == 3) ? 1 : 0));
        end
      end
    end

    // Config writes and start while busy are ignored.
    rmode = 0;
    for (int s = 0; s < NL; s++) set_slot(s, 3, 0, 0, 0);
    set_slot(6, 2, 0, 0, 0);
    clear_rec();
    gen_expected();
    start = 1'b1;
    tick();
    start = 1'b0;
    cfg_write(5, 1, 0, 0, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    seen_done = 0;
    for (int c = 0; c < 50 && seen_done == 0; c++) begin
      if (done) seen_done = 1;
      else tick();
    end
    check("busy_gate_done", 128'(seen_done), 128'(1));
    repeat (6) tick();
    check("busy_gate_no_rerun", 128'({busy, ucode_valid}), 128'(0));
    check("busy_gate_words", 128'(n_words), 128'(1));
    exp_q.delete();
    clear_rec();
    gen_expected();
    run_and_wait("busy_gate_rerun");
    check("busy_gate_rerun_words", 128'(n_words), 128'(1));
    exp_q.delete();

    // Reset in the middle of a run aborts with no done.
    for (int s = 0; s < NL; s++) set_slot(s, 3, 0, 0, 0);
    set_slot(0, 0, 2, 1, 3);
    clear_rec();
    gen_expected();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (10) tick();
    check("midrun_busy_before", 128'(busy), 128'(1));
    rst_n = 1'b0;
    #1;
    check("midrun_rst_outs", 128'({busy, done, ucode_valid}), 128'(0));
    check("midrun_rst_pipe", 128'(pipeline_ucode), 128'(0));
    exp_q.delete();
    tick();
    tick();
    rst_n = 1'b1;
    seen_done = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (done || ucode_valid || busy) seen_done = 1;
    end
    check("midrun_no_done", 128'(seen_done), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ucode_sequencer.md
UCODE_SEQUENCER -- requirements
Module: ucode_sequencer

Interface
REQ-001 Parameter NUM_LAYERS, default 7: number of layer slots; the Mode field is one-hot NUM_LAYERS wide, with slot 0 in the MSB.
REQ-002 Parameter W_BITS, default 9: width-counter and Width-field width.
REQ-003 Parameter D_BITS, default 5: depth-counter and Depth-field width.
REQ-004 Parameter H_BITS, default 4: height-counter width.
REQ-005 Parameter LANES, default 5: FC data-read stride (multiplier lanes).
REQ-006 Clk  in  1: sole clock, rising edge.
REQ-007 Rst_n  in  1: reset, asynchronous, active-low.
REQ-008 Cfg_we  in  1: configuration write strobe.
REQ-009 Cfg_slot  in  clog2(NUM_LAYERS): slot being written.
REQ-010 Cfg_kind  in  2: layer kind; 0=CONV, 1=POOL, 2=FC, 3=disabled.
REQ-011 Cfg_w_max, Cfg_d_max, Cfg_h_max  in  W_BITS/D_BITS/H_BITS: inclusive loop bounds.
REQ-012 Start  in  1: single-cycle run request.
REQ-013 Busy  out  1: high from the accepted Start until Done.
REQ-014 Done  out  1: one-cycle pulse when the run completes.
REQ-015 Ucode_valid  out  1: the word bundle on the four uCode outputs is valid.
REQ-016 Ucode_ready  in  1: downstream accepts the bundle; a transfer ("fire") occurs when valid and ready are both high.
REQ-017 Pipeline_uCode  out  16: [15:14] comparator ctrl, [13] write mux, [12] adder input, [11:10] adder ctrl, [9:4] mul path enables, [3] mul mux ctrl, [2] mul mux sel, [1] ALU mux, [0] compute done.
REQ-018 Data_Read_uCode, Data_Write_uCode  out  W_BITS+D_BITS+NUM_LAYERS+1: {Width, Depth, Mode, Enable}.
REQ-019 Weight_Read_uCode  out  4+D_BITS+NUM_LAYERS+1: {Idx[3:0], Depth, Mode, Enable}.

Function
REQ-020 Per-slot descriptor table (kind, w_max, d_max, h_max) SHALL be written on Cfg_we; writes while Busy SHALL be ignored.
REQ-021 FSM states: IDLE, SEEK, EMIT, DONE.
REQ-022 IDLE->SEEK on Start; Start while Busy SHALL be ignored.
REQ-023 SEEK advances to the next slot whose kind is not 3, entering EMIT with h=w=d=0; when no slots remain it SHALL go to DONE.
REQ-024 Loop order: h innermost (CONV only; held at 0 otherwise), then w, then d outermost; counters advance only on fire.
REQ-025 After the fire of the last word in a slot (h,w,d all at max), SHALL return to SEEK.
REQ-026 DONE asserts Done for one cycle, then returns to IDLE; all slots disabled gives Done exactly 2 cycles after Start.
REQ-027 Outputs SHALL be registered: the bundle for a counter tuple appears 1 cycle after that tuple becomes current; valid is deasserted in SEEK, DONE and IDLE.
REQ-028 While valid && !ready, all uCode outputs and the counters SHALL hold stable.
REQ-029 CONV: pipe = {01, 0, h!=0, (h==h_max)?11:00, (h==0)?111100:011100, 0000}; weight = {h, d, mode, 1}; read = {w, h zero-extended, mode, 1}; write = {w, d, mode, h==h_max}.
REQ-030 POOL: pipe = 16'b01_0_0_00_000000_1110; weight = 0; read = {w<<1 truncated to W_BITS, d, mode, 1}; write = {w, d, mode, 1}.
REQ-031 FC: pipe = {01, 0, w!=0, (w==w_max)?11:00, (w==0)?111111:011111, 000, last}; weight = {w[3:0], d, mode, 1}; read = {w*LANES truncated to W_BITS, 0, mode, 1}; write = {d zero-extended, 0, mode, w==w_max}.
REQ-032 In the FC rule, "last" (pipe[0]) SHALL be 1 only on the final word of the final enabled slot.
REQ-033 Counter wrap SHALL be exact at max: a bound of 0 means one iteration; no overflow beyond the field width.

Reset
REQ-034 Rst_n low SHALL asynchronously force the FSM to IDLE, clear all counters and outputs (Busy, Done, Ucode_valid and all uCode words to 0), and set every descriptor's kind to 3.
REQ-035 Reset mid-run SHALL abort with no Done pulse.

Structure
REQ-036 Shared package ucode_pkg SHALL hold the layer-kind enum, the pipeline bit-index constants and the Mode one-hot helper.
REQ-037 One sub-module, ucode_loop_ctr, SHALL implement the nested h/w/d counters with a last-iteration flag.

Verification
REQ-038 Slot 0 CONV (w_max=1, d_max=0, h_max=1), ready held high: exactly 4 words; write enable=1 only at h=1; pipe[11:10]=11 at h=1.
REQ-039 POOL w_max=3, d_max=1: read Width sequence 0,2,4,6 per d; weight word=0; 8 words total.
REQ-040 FC as final slot, w_max=3, LANES=5: read Widths 0,5,10,15; pipe[0]=1 only on the 4th word; Done follows.
REQ-041 Ready toggled every other cycle during CONV: outputs are stable while stalled; word count and order match the ready-high run.
REQ-042 All slots disabled, Start: Done exactly 2 cycles later with no valid; then Rst_n pulsed mid-run: valid=0, Busy=0, no Done.
